id_inst_queue: RTL and testbench

//  Parametrised decode-side instruction queue between fetch and the per-slot decoders.

---
 rtl/id_inst_queue_pkg.sv | 39 +++
 rtl/id_inst_queue_class.sv | 35 +++
 rtl/id_inst_queue.sv | 122 ++++++++++++
 tb/tb_id_inst_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_inst_queue_pkg.sv
// Shared constants and types for the decode-side instruction queue:
// opcode/funct encodings used by the classifier and the class-bit layout.
package id_inst_queue_pkg;

  // Class vector {is_brj, is_mem, is_hilo}
  typedef logic [2:0] id_cls_t;

  localparam int ID_CLS_BRJ  = 2;
  localparam int ID_CLS_MEM  = 1;
  localparam int ID_CLS_HILO = 0;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SH      = 6'b101001;
  localparam logic [5:0] OP_SW      = 6'b101011;

  // SPECIAL funct codes
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  // HI/LO group: MFHI/MTHI/MFLO/MTLO (0100xx) and MULT/MULTU/DIV/DIVU (0110xx)
  function automatic logic is_hilo_funct(input logic [5:0] funct);
    return (funct[5:2] == 4'b0100) || (funct[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/id_inst_queue_class.sv
// Enqueue-side pre-classifier: instruction word -> {is_brj, is_mem, is_hilo}.
// Purely combinational; one instance per fetch slot so the issue path only
// ever sees stored class bits.
module id_issue_class
  import id_inst_queue_pkg::*;
(
  input  logic [31:0] inst,
  output id_cls_t     cls
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_bits;

  assign opcode      = inst[31:26];
  assign funct       = inst[5:0];
  assign unused_bits = ^inst[25:6];

  // Decode opcode/funct into the three class flags
  always_comb begin
    cls = '0;
    case (opcode)
      OP_SPECIAL: begin
        cls[ID_CLS_BRJ]  = (funct == FN_JR) || (funct == FN_JALR);
        cls[ID_CLS_HILO] = is_hilo_funct(funct);
      end
      OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
        cls[ID_CLS_BRJ] = 1'b1;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW:
        cls[ID_CLS_MEM] = 1'b1;
      default: cls = '0;
    endcase
  end

endmodule

// File: rtl/id_inst_queue.sv
// Decode-side instruction queue: DEPTH-entry circular buffer fed by up to
// FETCH_W instructions per cycle, issuing a contiguous group of up to ISSUE_W
// oldest entries per cycle under branch/mem/hilo pairing limits.
module id_inst_queue
  import id_inst_queue_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic [FETCH_W-1:0]      in_valid,
  input  logic [32*FETCH_W-1:0]   in_inst,
  input  logic [32*FETCH_W-1:0]   in_pc,
  output logic                    in_ready,
  output logic [ISSUE_W-1:0]      out_valid,
  output logic [32*ISSUE_W-1:0]   out_inst,
  output logic [32*ISSUE_W-1:0]   out_pc,
  input  logic [ISSUE_W-1:0]      out_accept,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic [31:0] inst_q [DEPTH];
  logic [31:0] pc_q   [DEPTH];
  id_cls_t     cls_q  [DEPTH];

  id_cls_t       in_cls  [FETCH_W];
  logic [PW-1:0] rd_idx  [ISSUE_W];
  id_cls_t       win_cls [ISSUE_W];

  logic [CW-1:0] enq_cnt;
  logic [CW-1:0] deq_cnt;
  logic          enq_en;

  for (genvar j = 0; j < FETCH_W; j++) begin : g_class
    id_issue_class u_class (
      .inst (in_inst[32*j +: 32]),
      .cls  (in_cls[j])
    );
  end

  // Ready looks only at registered occupancy, so fetch never sees a
  // combinational path from the downstream accept.
  assign in_ready = (count <= CW'(DEPTH - FETCH_W));
  assign enq_en   = in_ready & ~flush;

  // Entry counts for this edge; in_valid is a contiguous prefix so slot j lands at tail+j
  always_comb begin
    enq_cnt = '0;
    deq_cnt = '0;
    if (in_ready) begin
      for (int j = 0; j < FETCH_W; j++) enq_cnt = enq_cnt + CW'(in_valid[j]);
    end
    for (int i = 0; i < ISSUE_W; i++) deq_cnt = deq_cnt + CW'(out_accept[i]);
  end

  // Pointer and occupancy update; flush wins over any same-cycle traffic
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + deq_cnt[PW-1:0];
      tail  <= tail + enq_cnt[PW-1:0];
      count <= count + enq_cnt - deq_cnt;
    end
  end

  // Entry RAM write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    for (int j = 0; j < FETCH_W; j++) begin
      if (enq_en && in_valid[j]) begin
        inst_q[tail + PW'(j)] <= in_inst[32*j +: 32];
        pc_q[tail + PW'(j)]   <= in_pc[32*j +: 32];
        cls_q[tail + PW'(j)]  <= in_cls[j];
      end
    end
  end

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_window
    assign rd_idx[i]            = head + PW'(i);
    assign out_inst[32*i +: 32] = inst_q[rd_idx[i]];
    assign out_pc[32*i +: 32]   = pc_q[rd_idx[i]];
    assign win_cls[i]           = cls_q[rd_idx[i]];
  end

  // Grow the issue group from slot 0; the first blocking slot closes it for
  // every later slot, which keeps out_valid a contiguous prefix.
  always_comb begin
    logic grp_open;
    logic mem_seen;
    logic hilo_seen;
    out_valid = '0;
    grp_open  = 1'b1;
    mem_seen  = 1'b0;
    hilo_seen = 1'b0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (count <= CW'(i))                          grp_open = 1'b0;
      if ((i > 0) && win_cls[i][ID_CLS_BRJ])        grp_open = 1'b0;
      if ((i > 1) && win_cls[0][ID_CLS_BRJ])        grp_open = 1'b0;
      if (mem_seen && win_cls[i][ID_CLS_MEM])       grp_open = 1'b0;
      if (hilo_seen && win_cls[i][ID_CLS_HILO])     grp_open = 1'b0;
      out_valid[i] = grp_open;
      mem_seen     = mem_seen  | win_cls[i][ID_CLS_MEM];
      hilo_seen    = hilo_seen | win_cls[i][ID_CLS_HILO];
    end
  end

endmodule

// File: tb/tb_id_inst_queue.sv
// Directed bench for id_inst_queue (FETCH_W=2, ISSUE_W=2, DEPTH=8).
module tb_id_inst_queue;

  localparam logic [31:0] ADDU = 32'h00221821;
  localparam logic [31:0] BEQ  = 32'h10220004;
  localparam logic [31:0] BNE  = 32'h14220003;
  localparam logic [31:0] J    = 32'h08000010;
  localparam logic [31:0] JR   = 32'h03E00008;
  localparam logic [31:0] LW   = 32'h8C220000;
  localparam logic [31:0] SW   = 32'hAC220000;
  localparam logic [31:0] LB   = 32'h80220000;
  localparam logic [31:0] LHU  = 32'h94220000;
  localparam logic [31:0] SB   = 32'hA0220000;
  localparam logic [31:0] MULT = 32'h00220018;
  localparam logic [31:0] MFLO = 32'h00001812;
  localparam logic [31:0] MTHI = 32'h00200011;
  localparam logic [31:0] DIV  = 32'h0022001A;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [1:0]  in_valid;
  logic [63:0] in_inst;
  logic [63:0] in_pc;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_inst;
  logic [63:0] out_pc;
  logic [1:0]  out_accept;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    int          n;
    logic [1:0]  exp_valid;
  } pv_t;

  pv_t pv [14];

  id_inst_queue #(.FETCH_W(2), .ISSUE_W(2), .DEPTH(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .out_accept (out_accept),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Downstream protocol: accept must be a prefix of out_valid
  always @(negedge clk) begin
    if (resetn) begin
      assert (((out_accept & ~out_valid) == 2'b00) &&
              ((out_accept & (out_accept + 2'd1)) == 2'b00))
      else begin
        bad++;
        $display("FAIL accept_prefix: accept=%b valid=%b", out_accept, out_valid);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] p0, input logic [31:0] p1);
    in_valid = v;
    in_inst  = {i1, i0};
    in_pc    = {p1, p0};
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    pv[0]  = '{"beq_delay",   BEQ,  ADDU, ADDU, 3, 2'b11};
    pv[1]  = '{"lw_sw",       LW,   SW,   ADDU, 2, 2'b01};
    pv[2]  = '{"mult_mflo",   MULT, MFLO, ADDU, 2, 2'b01};
    pv[3]  = '{"addu_j",      ADDU, J,    ADDU, 2, 2'b01};
    pv[4]  = '{"addu_addu",   ADDU, ADDU, ADDU, 2, 2'b11};
    pv[5]  = '{"lw_mflo",     LW,   MFLO, ADDU, 2, 2'b11};
    pv[6]  = '{"mult_addu",   MULT, ADDU, ADDU, 2, 2'b11};
    pv[7]  = '{"jr_delay",    JR,   ADDU, ADDU, 2, 2'b11};
    pv[8]  = '{"addu_jr",     ADDU, JR,   ADDU, 2, 2'b01};
    pv[9]  = '{"mthi_div",    MTHI, DIV,  ADDU, 2, 2'b01};
    pv[10] = '{"lb_lhu",      LB,   LHU,  ADDU, 2, 2'b01};
    pv[11] = '{"lone_j",      J,    ADDU, ADDU, 1, 2'b01};
    pv[12] = '{"sb_bne",      SB,   BNE,  ADDU, 2, 2'b01};
    pv[13] = '{"beq_lw",      BEQ,  LW,   ADDU, 2, 2'b11};

    resetn     = 1'b0;
    flush      = 1'b0;
    in_valid   = 2'b00;
    in_inst    = '0;
    in_pc      = '0;
    out_accept = 2'b00;
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    resetn = 1'b1;
    step();

    // Reset in the middle of traffic, observed before any clock edge
    offer(2'b11, ADDU, ADDU, 32'h0, 32'h4);   step();
    offer(2'b11, ADDU, ADDU, 32'h8, 32'hC);   step();
    offer(2'b01, ADDU, ADDU, 32'h10, 32'h14); step();
    offer(2'b00, ADDU, ADDU, 32'h0, 32'h0);
    check("mid_count5", 32'(count), 32'd5);
    #3 resetn = 1'b0;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_ready", 32'(in_ready), 32'd1);
    step();
    resetn = 1'b1;
    step();

    // Fill to DEPTH, one extra offer must be dropped, then drain in order
    for (int c = 0; c < 4; c++) begin
      offer(2'b11, ADDU, ADDU, 32'(8*c), 32'(8*c+4));
      step();
    end
    check("full_count", 32'(count), 32'd8);
    check("full_ready", 32'(in_ready), 32'd0);
    offer(2'b11, ADDU, ADDU, 32'h20, 32'h24);
    step();
    offer(2'b00, ADDU, ADDU, 32'h0, 32'h0);
    check("full_hold", 32'(count), 32'd8);
    for (int d = 0; d < 4; d++) begin
      check("drain_valid", 32'(out_valid), 32'd3);
      check("drain_pc0", out_pc[31:0], 32'(8*d));
      check("drain_pc1", out_pc[63:32], 32'(8*d+4));
      out_accept = 2'b11;
      step();
    end
    out_accept = 2'b00;
    check("drain_empty", 32'(count), 32'd0);
    check("drain_valid0", 32'(out_valid), 32'd0);

    // Steady enqueue 2 / accept 2 across pointer wrap
    offer(2'b11, ADDU, ADDU, 32'h100, 32'h104);
    step();
    for (int i = 0; i < 20; i++) begin
      offer(2'b11, ADDU, ADDU, 32'(32'h108 + 8*i), 32'(32'h10C + 8*i));
      out_accept = 2'b11;
      check("wrap_count", 32'(count), 32'd2);
      check("wrap_pc0", out_pc[31:0], 32'(32'h100 + 8*i));
      check("wrap_pc1", out_pc[63:32], 32'(32'h104 + 8*i));
      step();
    end
    offer(2'b00, ADDU, ADDU, 32'h0, 32'h0);
    out_accept = 2'b00;
    check("wrap_end", 32'(count), 32'd2);
    check("wrap_end_pc", out_pc[31:0], 32'h1A0);

    // Pairing vectors
    for (int k = 0; k < 14; k++) begin
      do_flush();
      if (pv[k].n == 1) begin
        offer(2'b01, pv[k].a, ADDU, 32'h500, 32'h0);
        step();
      end else begin
        offer(2'b11, pv[k].a, pv[k].b, 32'h500, 32'h504);
        step();
        if (pv[k].n == 3) begin
          offer(2'b01, pv[k].c, ADDU, 32'h508, 32'h0);
          step();
        end
      end
      offer(2'b00, ADDU, ADDU, 32'h0, 32'h0);
      check({pv[k].name, "_valid"}, 32'(out_valid), 32'(pv[k].exp_valid));
      check({pv[k].name, "_inst0"}, out_inst[31:0], pv[k].a);
    end

    // Flush while enqueuing and accepting
    do_flush();
    offer(2'b11, ADDU, ADDU, 32'h200, 32'h204); step();
    offer(2'b01, ADDU, ADDU, 32'h208, 32'h0);   step();
    check("pre_flush_count", 32'(count), 32'd3);
    offer(2'b11, ADDU, ADDU, 32'h210, 32'h214);
    out_accept = 2'b01;
    flush      = 1'b1;
    step();
    flush      = 1'b0;
    out_accept = 2'b00;
    offer(2'b00, ADDU, ADDU, 32'h0, 32'h0);
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    offer(2'b01, ADDU, ADDU, 32'h300, 32'h0);
    step();
    offer(2'b00, ADDU, ADDU, 32'h0, 32'h0);
    check("post_flush_count", 32'(count), 32'd1);
    check("post_flush_pc", out_pc[31:0], 32'h300);
    check("post_flush_valid", 32'(out_valid), 32'd1);

    // Partial fetch group followed by a full one
    do_flush();
    offer(2'b01, ADDU, ADDU, 32'h40, 32'h0);  step();
    offer(2'b11, ADDU, ADDU, 32'h44, 32'h48); step();
    offer(2'b00, ADDU, ADDU, 32'h0, 32'h0);
    check("partial_count", 32'(count), 32'd3);
    check("partial_pc0", out_pc[31:0], 32'h40);
    check("partial_pc1", out_pc[63:32], 32'h44);
    out_accept = 2'b11;
    step();
    out_accept = 2'b00;
    check("partial_pc2", out_pc[31:0], 32'h48);
    check("partial_valid", 32'(out_valid), 32'd1);
    check("partial_left", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
